// File: rtl/rr_seqdet_sched.sv
// Round-robin scheduler sharing one serial Moore pattern-detector engine.
// Each granted job clears the engine, shifts the latched word in LSB first,
// counts the cycles in which the engine output is high and reports the
// count together with the requester index on a one-cycle done pulse.
module rr_seqdet_sched #(
   parameter int NREQ = 4,
   parameter int LEN  = 8,
   parameter int IDW  = $clog2(NREQ),
   parameter int CW   = $clog2(LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN-1:0]   data,
   output logic [NREQ-1:0]       gnt,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic [CW-1:0]         hit_cnt,
   output logic                  eng_clr,
   output logic                  eng_w,
   input  logic                  eng_z
);

   localparam int BW = $clog2(LEN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [IDW-1:0]  sel_q,   sel_d;
   logic [IDW-1:0]  last_q,  last_d;
   logic [LEN-1:0]  word_q,  word_d;
   logic [BW-1:0]   idx_q,   idx_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [IDW-1:0]  id_q,    id_d;
   logic [CW-1:0]   hit_q,   hit_d;

   logic            any_req;
   logic [IDW-1:0]  pick;
   logic            busy;
   logic [LEN-1:0]  words [NREQ];

   // Split the flat data bus into one word per requester.
   for (genvar g = 0; g < NREQ; g++) begin : g_words
      assign words[g] = data[g*LEN +: LEN];
   end

   // Rotating-priority search: first set request after the last one served.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any_req && req[IDW'((int'(last_q) + k) % NREQ)]) begin
            any_req = 1'b1;
            pick    = IDW'((int'(last_q) + k) % NREQ);
         end
      end
   end

   // Job sequencing: IDLE -> CLEAR -> SHIFT x LEN -> DRAIN -> DONE -> IDLE.
   always_comb begin
      // NOTE: every _d defaults to its _q first so no path can infer a latch.
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      word_d  = word_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      hit_d   = hit_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               sel_d   = pick;
               word_d  = words[pick];
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            // The idx=0 sample shows the freshly cleared state, not a result.
            if (idx_q != '0) cnt_d = cnt_q + CW'(eng_z);
            if (idx_q == BW'(LEN - 1)) state_d = S_DRAIN;
            else                       idx_d   = idx_q + BW'(1);
         end
         S_DRAIN: begin
            // Last sample reflects the state after the final bit.
            hit_d   = cnt_q + CW'(eng_z);
            id_d    = sel_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            last_d  = sel_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset leaves requester 0 with the highest priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         last_q  <= IDW'(NREQ - 1);
         word_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         id_q    <= '0;
         hit_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         hit_q   <= hit_d;
      end
   end

   assign busy    = (state_q == S_CLEAR) || (state_q == S_SHIFT) || (state_q == S_DRAIN);
   assign gnt     = busy ? (NREQ'(1) << sel_q) : '0;
   assign done    = (state_q == S_DONE);
   assign done_id = id_q;
   assign hit_cnt = hit_q;
   // Engine is held cleared for as long as reset is asserted.
   assign eng_clr = ~reset | (state_q == S_CLEAR);
   assign eng_w   = (state_q == S_SHIFT) & word_q[idx_q];

endmodule

// File: tb/tb_rr_seqdet_sched.sv
// Self-checking bench for rr_seqdet_sched: a behavioural engine, directed
// jobs with known hit counts, and randomized traffic checked by a monitor
// that predicts grant order and hit counts from the arbitration rules.
module tb_rr_seqdet_sched;

   localparam int NREQ = 4;
   localparam int LEN  = 8;
   localparam int IDW  = 2;
   localparam int CW   = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*LEN-1:0] data = '0;
   logic [NREQ-1:0]     gnt;
   logic                done;
   logic [IDW-1:0]      done_id;
   logic [CW-1:0]       hit_cnt;
   logic                eng_clr;
   logic                eng_w;
   logic                eng_z;

   int n_checks = 0;
   int n_errors = 0;

   rr_seqdet_sched #(.NREQ(NREQ), .LEN(LEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .data    (data),
      .gnt     (gnt),
      .done    (done),
      .done_id (done_id),
      .hit_cnt (hit_cnt),
      .eng_clr (eng_clr),
      .eng_w   (eng_w),
      .eng_z   (eng_z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Engine states A..F as 0..5; z is high in E and F.
   function automatic int eng_next(input int s, input logic w);
      case (s)
         0: return w ? 1 : 0;
         1: return w ? 2 : 3;
         2: return w ? 4 : 3;
         3: return w ? 5 : 0;
         4: return w ? 4 : 3;
         5: return w ? 2 : 3;
         default: return 0;
      endcase
   endfunction

   int eng_st = 0;
   always @(posedge clk) eng_st <= eng_clr ? 0 : eng_next(eng_st, eng_w);
   assign eng_z = (eng_st >= 4);

   // Expected hits: walk the word from a cleared engine, count z after each bit.
   function automatic int ref_hits(input logic [LEN-1:0] w);
      int s = 0;
      int n = 0;
      for (int i = 0; i < LEN; i++) begin
         s = eng_next(s, w[i]);
         if (s >= 4) n++;
      end
      return n;
   endfunction

   function automatic int arb(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // Monitor: samples on the falling edge, predicts grants and results.
   logic [NREQ-1:0]     p_gnt = '0;
   logic [NREQ-1:0]     p_req = '0;
   logic [NREQ*LEN-1:0] p_data = '0;
   logic                p_done = 1'b0;
   bit                  p_rst_ok = 1'b0;
   bit                  pend = 1'b0;
   int                  last_m = NREQ - 1;
   int                  e_id = -1;
   int                  e_hits = 0;
   int                  rise_cyc = 0;
   int                  cyc = 0;

   always @(negedge clk) begin
      int e;
      cyc++;
      if (!reset) begin
         check("rst_gnt", gnt, 0);
         check("rst_done", done, 0);
         check("rst_eng_clr", eng_clr, 1);
         last_m   = NREQ - 1;
         pend     = 1'b0;
         p_rst_ok = 1'b0;
      end else begin
         if (p_rst_ok) begin
            if (p_gnt == 0 && gnt != 0) begin
               e = arb(p_req, last_m);
               check("grant", gnt, (e < 0) ? 0 : (1 << e));
               check("clr_in_clear", eng_clr, 1);
               pend     = 1'b1;
               e_id     = e;
               e_hits   = (e < 0) ? 0 : ref_hits(p_data[e*LEN +: LEN]);
               rise_cyc = cyc;
            end else begin
               check("clr_low", eng_clr, 0);
               if (p_gnt == 0 && !p_done && p_req != 0) check("idle_gap", gnt != 0, 1);
            end
            if (gnt != 0) check("onehot", $onehot(gnt), 1);
            if (p_done) check("gnt_after_done", gnt, 0);
            if (done) begin
               check("done_expected", pend, 1);
               check("done_id", done_id, e_id);
               check("hit_cnt", hit_cnt, e_hits);
               check("latency", cyc - rise_cyc, LEN + 2);
               check("gnt_in_done", gnt, 0);
               last_m = e_id;
               pend   = 1'b0;
            end
         end
         p_rst_ok = 1'b1;
      end
      p_gnt  = gnt;
      p_req  = req;
      p_done = done;
      p_data = data;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_word(input int i, input logic [LEN-1:0] w);
      data[i*LEN +: LEN] = w;
   endtask

   task automatic wait_gnt(input int i);
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (gnt[i]) ok = 1'b1;
      end
      if (!ok) check("gnt_timeout", gnt[i], 1);
   endtask

   task automatic wait_done(output int id, output int hits);
      bit ok = 1'b0;
      id   = -1;
      hits = -1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (done) begin
            ok   = 1'b1;
            id   = int'(done_id);
            hits = int'(hit_cnt);
         end
      end
      if (!ok) check("done_timeout", done, 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic run_one(input logic [LEN-1:0] w, input int exp, input string tag);
      int id;
      int hits;
      set_word(0, w);
      req = 4'b0001;
      wait_gnt(0);
      tick();
      req = '0;
      wait_done(id, hits);
      check({tag, "_id"}, id, 0);
      check({tag, "_hits"}, hits, exp);
      tick();
   endtask

   initial begin
      int id;
      int hits;
      logic [LEN-1:0] w;
      logic [LEN-1:0] words [3];
      int exps [3];

      reset = 1'b0;
      tick(3);
      check("rst_done_id", done_id, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      reset = 1'b1;

      // Directed words with hand-derived hit counts.
      run_one(8'h07, 1, "t1");
      words[0] = 8'hFF; exps[0] = 6;
      words[1] = 8'h00; exps[1] = 0;
      words[2] = 8'h0B; exps[2] = 1;
      for (int i = 0; i < 3; i++) run_one(words[i], exps[i], "t2");

      // All requesters held: strict rotation starting from 0.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         w = LEN'($urandom);
         w[1:0] = 2'(i);
         set_word(i, w);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_done(id, hits);
         check("t3_order", id, k % NREQ);
      end

      // Requester 2 drops its request mid-job.
      wait_gnt(2);
      tick(3);
      req[2] = 1'b0;
      wait_done(id, hits);
      check("t4_id", id, 2);
      for (int k = 0; k < 3; k++) begin
         wait_done(id, hits);
         check("t4_not2", id == 2, 0);
      end

      // Asynchronous reset in the middle of a job.
      wait_gnt(3);
      tick(4);
      #2;
      reset = 1'b0;
      req   = 4'b1001;
      #1;
      check("t5_gnt", gnt, 0);
      check("t5_eng_clr", eng_clr, 1);
      check("t5_done", done, 0);
      check("t5_hit_cnt", hit_cnt, 0);
      check("t5_done_id", done_id, 0);
      tick(2);
      reset = 1'b1;
      wait_done(id, hits);
      check("t5_first", id, 0);
      tick();
      req = '0;
      tick(3);

      // Data changes after the grant must not affect the result.
      w = LEN'($urandom);
      set_word(2, w);
      req = 4'b0100;
      wait_gnt(2);
      tick();
      set_word(2, ~w);
      req = '0;
      wait_done(id, hits);
      check("t6_id", id, 2);
      check("t6_hits", hits, ref_hits(w));
      tick(2);

      // Randomized traffic checked by the monitor.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) set_word(i, LEN'($urandom));
         tick();
      end
      req = '0;
      tick(20);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/rr_seqdet_sched.md
Name: rr_seqdet_sched

Overview:
- Round-robin scheduler that shares one serial pattern-detector engine among NREQ requesters.
- The engine is an external Moore FSM with its own clk, a synchronous clear, a one-bit input w and a one-bit output z.
- For each granted requester, the scheduler clears the engine, shifts the latched LEN-bit word into it LSB first, counts the cycles in which z is high, and reports the count with a done pulse.

Parameters:
- NREQ, 4, number of requesters (2..16).
- LEN, 8, bits per job (2..64).
- IDW, $clog2(NREQ), width of the requester index.
- CW, $clog2(LEN+1), width of the hit count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request, one bit per requester.
- data  in  NREQ*LEN  job words; requester i owns bits [i*LEN +: LEN].
- gnt  out  NREQ  one-hot grant, high for the whole job.
- done  out  1  one-cycle pulse when a result is valid.
- done_id  out  IDW  index of the finished requester.
- hit_cnt  out  CW  number of z=1 samples in the job.
- eng_clr  out  1  synchronous clear to the engine (engine returns to its initial state on the next edge).
- eng_w  out  1  serial bit to the engine.
- eng_z  in  1  engine output (Moore: reflects the state after the previous w).

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - gnt=0, done=0, done_id=0, hit_cnt=0, eng_w=0.
  - eng_clr=1, so the engine is cleared while reset is held.
  - Round-robin pointer set so that requester 0 has highest priority.
  - A reset mid-job abandons the job: no done, no result.
- IDLE:
  - eng_clr=0, eng_w=0.
  - If any req bit is high, choose the first set bit searching upward, circularly, from (last_served+1) mod NREQ.
  - Latch that requester's data word and index; go to CLEAR.
- CLEAR (1 cycle):
  - gnt[sel]=1, eng_clr=1, eng_w=0.
  - Bit index cleared to 0, internal count cleared to 0.
- SHIFT (LEN cycles, idx 0..LEN-1):
  - eng_w = word[idx].
  - eng_z is added to the count when idx>=1; the idx=0 sample is the cleared state and is ignored.
  - Go to DRAIN after idx=LEN-1.
- DRAIN (1 cycle):
  - eng_w=0; eng_z is added to the count (the state after the last bit).
- DONE (1 cycle):
  - done=1; done_id and hit_cnt updated with this job's values.
  - gnt=0; last_served=sel; return to IDLE.
- Result holding: done_id and hit_cnt hold their values until the next DONE.
- Latency: CLEAR to done pulse is LEN+2 cycles. A requester is re-arbitrated no earlier than 1 cycle after done.
- Fairness: a requester holding req continuously is re-served only after every other active requester is served once.
- Request changes:
  - req dropped during a job: the job completes and is reported.
  - req changes while not in IDLE: ignored.
  - data is sampled only at the IDLE→CLEAR edge.
- Width rule: hit_cnt ≤ LEN, which always fits CW bits; no saturation logic is needed.
- Simultaneous requests: resolved strictly by the rotating priority; exactly one gnt bit is high.

Test Plan:
The bench models the engine with states A–F (A:w?B:A, B:w?C:D, C:w?E:D, D:w?F:A, E:w?E:D, F:w?C:D), z=1 in E or F, cleared to A by eng_clr.
1. Release reset, req=4'b0001, data0=8'h07 → gnt=0001 for 10 cycles; done after CLEAR+10; done_id=0, hit_cnt=1.
2. data0=8'hFF → hit_cnt=6. data0=8'h00 → hit_cnt=0. data0=8'h0B (1,1,0,1,…) → hit_cnt=1 via state F.
3. req=4'b1111 held, distinct words → grant order 0,1,2,3,0; done_id follows the same order; gnt is always one-hot; no gap greater than 1 IDLE cycle between jobs.
4. req[2] dropped mid-SHIFT → its job still completes with the correct hit_cnt; it is not granted again.
5. reset pulsed low mid-SHIFT → gnt=0 and eng_clr=1 immediately (asynchronous). No done. After release, req[3] and req[0] both high → 0 is served first.
6. data changed during a job → hit_cnt reflects the word latched at grant.
